window_reducer: RTL and testbench

- Versat functional unit sitting directly downstream of the address/value generator unit.
- Consumes one data word per cycle on in0, typically a generated sequence, and reduces fixed-length windows of samples into a single result.
- Reduction is either wrap-around sum or signed maximum.
- Publishes the last completed window result on out0 and a completed-window count on out1, so later units can consume per-window results.

---
 rtl/window_reducer.sv | 141 ++++++++++++++
 tb/tb_window_reducer.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/window_reducer.sv
`default_nettype none
// ============================================================================
// Module      : window_reducer
// Description : Reduces fixed-length windows of a sample stream into one
//               result (wrap-around sum or signed maximum). Publishes the last
//               completed window result and a count of completed windows.
// Revision    : 1.0 - initial release
// ============================================================================
module window_reducer #(
  parameter int DATA_W   = 32,
  parameter int PERIOD_W = 16,
  parameter int DELAY_W  = 7
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                running,
  input  logic                run,
  input  logic [DATA_W-1:0]   in0,
  input  logic [PERIOD_W-1:0] period,
  input  logic                mode,
  input  logic [DELAY_W-1:0]  delay0,
  output logic [DATA_W-1:0]   out0,
  output logic [DATA_W-1:0]   out1
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DELAY = 2'd1,
    S_ACCUM = 2'd2
  } state_t;

  localparam logic [PERIOD_W-1:0] c_PERIOD_ONE = PERIOD_W'(1);
  localparam logic [DELAY_W-1:0]  c_DELAY_ONE  = DELAY_W'(1);

  state_t              r_state;
  state_t              w_state_nxt;
  logic [DELAY_W-1:0]  r_dcnt;
  logic [PERIOD_W-1:0] r_scnt;
  logic [PERIOD_W-1:0] r_period;
  logic                r_mode;
  logic [DATA_W-1:0]   r_acc;
  logic [DATA_W-1:0]   r_out0;
  logic [DATA_W-1:0]   r_out1;

  logic [PERIOD_W-1:0] w_period_eff;
  logic                w_first;
  logic                w_last;
  logic [DATA_W-1:0]   w_nxt;

  assign out0 = r_out0;
  assign out1 = r_out1;

  // A zero window length behaves as a one-sample window.
  assign w_period_eff = (r_period == '0) ? c_PERIOD_ONE : r_period;
  assign w_first      = (r_scnt == '0);
  assign w_last       = (r_scnt == (w_period_eff - c_PERIOD_ONE));

  // Reduction step: first sample seeds the window, later samples fold in.
  always_comb begin
    w_nxt = in0;
    if (!w_first) begin
      if (r_mode) begin
        // Ties keep the accumulator.
        w_nxt = ($signed(in0) > $signed(r_acc)) ? in0 : r_acc;
      end else begin
        w_nxt = r_acc + in0;
      end
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic: run always re-arms; otherwise advance only when running.
  always_comb begin
    w_state_nxt = r_state;
    if (run) begin
      w_state_nxt = (delay0 != '0) ? S_DELAY : S_ACCUM;
    end else if (running) begin
      case (r_state)
        S_DELAY: begin
          // Count of zero cannot normally occur here; treat it as expired.
          if (r_dcnt <= c_DELAY_ONE) begin
            w_state_nxt = S_ACCUM;
          end
        end
        S_ACCUM: w_state_nxt = S_ACCUM;
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  // Datapath: config latch, delay/sample counters, accumulator and outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_dcnt   <= '0;
      r_scnt   <= '0;
      r_period <= '0;
      r_mode   <= 1'b0;
      r_acc    <= '0;
      r_out0   <= '0;
      r_out1   <= '0;
    end else if (run) begin
      // Re-arm: any window in flight is abandoned without publishing.
      r_period <= period;
      r_mode   <= mode;
      r_dcnt   <= delay0;
      r_scnt   <= '0;
      r_acc    <= '0;
      r_out0   <= '0;
      r_out1   <= '0;
    end else if (running) begin
      case (r_state)
        S_DELAY: begin
          r_dcnt <= r_dcnt - c_DELAY_ONE;
        end
        S_ACCUM: begin
          if (w_last) begin
            // Accumulator is left as is; the next sample reseeds it.
            r_out0 <= w_nxt;
            r_out1 <= r_out1 + DATA_W'(1);
            r_scnt <= '0;
          end else begin
            r_acc  <= w_nxt;
            r_scnt <= r_scnt + c_PERIOD_ONE;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_window_reducer.sv
`default_nettype none
// ============================================================================
// Module      : tb_window_reducer
// Description : Directed self-checking bench for window_reducer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_window_reducer;

  localparam int DATA_W   = 32;
  localparam int PERIOD_W = 16;
  localparam int DELAY_W  = 7;

  logic                clk;
  logic                rst;
  logic                running;
  logic                run;
  logic [DATA_W-1:0]   in0;
  logic [PERIOD_W-1:0] period;
  logic                mode;
  logic [DELAY_W-1:0]  delay0;
  logic [DATA_W-1:0]   out0;
  logic [DATA_W-1:0]   out1;

  int n_total;
  int n_bad;

  window_reducer #(
    .DATA_W   (DATA_W),
    .PERIOD_W (PERIOD_W),
    .DELAY_W  (DELAY_W)
  ) u_dut (
    .clk     (clk),
    .rst     (rst),
    .running (running),
    .run     (run),
    .in0     (in0),
    .period  (period),
    .mode    (mode),
    .delay0  (delay0),
    .out0    (out0),
    .out1    (out1)
  );

  // Free-running clock, 10 time units per cycle.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [DATA_W-1:0] got,
                     input logic [DATA_W-1:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  // Advance one clock and settle just after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Single run pulse with the given configuration; running stays high.
  task automatic arm(input logic [PERIOD_W-1:0] p, input logic m,
                     input logic [DELAY_W-1:0] d);
    period  = p;
    mode    = m;
    delay0  = d;
    run     = 1'b1;
    running = 1'b1;
    in0     = 32'd99;
    tick();
    run     = 1'b0;
  endtask

  task automatic feed(input logic [DATA_W-1:0] v);
    in0     = v;
    running = 1'b1;
    tick();
  endtask

  initial begin
    n_total = 0;
    n_bad   = 0;
    rst     = 1'b0;
    running = 1'b1;
    run     = 1'b0;
    in0     = 32'hDEAD_BEEF;
    period  = 16'd3;
    mode    = 1'b1;
    delay0  = 7'd5;

    // Reset values, then hold without a run pulse.
    #3;
    chk("rst_out0", out0, 32'd0);
    chk("rst_out1", out1, 32'd0);
    tick();
    rst = 1'b1;
    tick();
    tick();
    chk("idle_out0", out0, 32'd0);
    chk("idle_out1", out1, 32'd0);

    // Sum mode, period 4, no delay.
    arm(16'd4, 1'b0, 7'd0);
    feed(32'd1);
    feed(32'd2);
    feed(32'd3);
    chk("sum_w1_pending", out1, 32'd0);
    feed(32'd4);
    chk("sum_w1_out0", out0, 32'd10);
    chk("sum_w1_out1", out1, 32'd1);
    feed(32'd5);
    feed(32'd6);
    feed(32'd7);
    chk("sum_w2_hold", out0, 32'd10);
    feed(32'd8);
    chk("sum_w2_out0", out0, 32'd26);
    chk("sum_w2_out1", out1, 32'd2);

    // Delay of 3 skipped samples, stall between the two window samples.
    arm(16'd2, 1'b0, 7'd3);
    chk("dly_clr_out0", out0, 32'd0);
    chk("dly_clr_out1", out1, 32'd0);
    feed(32'd9);
    feed(32'd9);
    feed(32'd9);
    feed(32'd5);
    running = 1'b0;
    in0 = 32'd100;
    tick();
    tick();
    chk("stall_out1", out1, 32'd0);
    feed(32'd6);
    chk("dly_out0", out0, 32'd11);
    chk("dly_out1", out1, 32'd1);

    // Signed maximum, period 3.
    arm(16'd3, 1'b1, 7'd0);
    feed(32'hFFFF_FFFB);
    feed(32'd7);
    feed(32'hFFFF_FFFE);
    chk("max_w1_out0", out0, 32'd7);
    chk("max_w1_out1", out1, 32'd1);
    feed(32'h8000_0000);
    feed(32'hFFFF_FFFF);
    feed(32'hFFFF_FFFD);
    chk("max_w2_out0", out0, 32'hFFFF_FFFF);
    chk("max_w2_out1", out1, 32'd2);

    // Period 0 behaves as 1: every sample is a window.
    arm(16'd0, 1'b0, 7'd0);
    feed(32'hFFFF_FFFF);
    chk("p0_a_out0", out0, 32'hFFFF_FFFF);
    chk("p0_a_out1", out1, 32'd1);
    feed(32'd2);
    chk("p0_b_out0", out0, 32'd2);
    chk("p0_b_out1", out1, 32'd2);

    // Sum wraps modulo 2^32.
    arm(16'd2, 1'b0, 7'd0);
    feed(32'hFFFF_FFFF);
    feed(32'd2);
    chk("wrap_out0", out0, 32'd1);

    // Restart mid-window aborts it; config changes after run are ignored.
    arm(16'd4, 1'b0, 7'd0);
    feed(32'd1);
    feed(32'd2);
    feed(32'd3);
    feed(32'd4);
    chk("rs_pre_out0", out0, 32'd10);
    feed(32'd1);
    feed(32'd2);
    arm(16'd4, 1'b0, 7'd0);
    chk("rs_clr_out0", out0, 32'd0);
    chk("rs_clr_out1", out1, 32'd0);
    period = 16'd1;
    mode   = 1'b1;
    feed(32'd1);
    feed(32'd1);
    feed(32'd1);
    chk("rs_cfg_hold", out1, 32'd0);
    feed(32'd1);
    chk("rs_out0", out0, 32'd4);
    chk("rs_out1", out1, 32'd1);

    // Asynchronous reset mid-operation clears outputs without a clock edge.
    feed(32'd1);
    #2;
    rst = 1'b0;
    #1;
    chk("arst_out0", out0, 32'd0);
    chk("arst_out1", out1, 32'd0);
    tick();
    rst = 1'b1;
    feed(32'd7);
    chk("arst_idle_out1", out1, 32'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
